// File: rtl/project_reset_sequencer.sv
// Per-project reset/select sequencer: parks every project for a settle period
// before releasing exactly one, so the harness never sees two projects enabled.
module project_reset_sequencer #(
  parameter int NUM_PROJECTS  = 4,
  parameter int ID_W          = 2,
  parameter int SETTLE_CYCLES = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    sel_valid,
  input  logic                    sel_enable,
  input  logic [ID_W-1:0]         sel_id,
  output logic                    sel_ready,
  output logic [NUM_PROJECTS-1:0] proj_reset,
  output logic [ID_W-1:0]         active_id,
  output logic                    running,
  output logic                    sel_error
);

  localparam int CNT_W = $clog2(SETTLE_CYCLES + 1);
  localparam logic [CNT_W-1:0]        CNT_LOAD   = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0]        CNT_ZERO   = {CNT_W{1'b0}};
  localparam logic [ID_W:0]           NUM_LIMIT  = (ID_W + 1)'(NUM_PROJECTS);
  localparam logic [NUM_PROJECTS-1:0] ALL_PARKED = {NUM_PROJECTS{1'b1}};
  localparam logic [ID_W-1:0]         ID_ZERO    = {ID_W{1'b0}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PARK = 2'd1,
    RUN  = 2'd2
  } state_t;

  state_t                  state_r, state_s;
  logic [CNT_W-1:0]        counter_r, counter_s;
  logic [ID_W-1:0]         target_r, target_s;
  logic [NUM_PROJECTS-1:0] proj_reset_r, proj_reset_s;
  logic [ID_W-1:0]         active_id_r, active_id_s;
  logic                    running_r, running_s;
  logic                    sel_error_r, sel_error_s;
  logic                    ready_s;
  logic                    accept_s;
  logic                    id_ok_s;

  // Active-low mask with only the chosen project's bit cleared.
  function automatic logic [NUM_PROJECTS-1:0] release_mask(input logic [ID_W-1:0] id);
    logic [NUM_PROJECTS-1:0] mask;
    mask = ALL_PARKED;
    for (int i = 0; i < NUM_PROJECTS; i++) begin
      mask[i] = (int'(id) == i) ? 1'b0 : 1'b1;
    end
    return mask;
  endfunction

  assign ready_s  = (state_r != PARK);
  assign accept_s = sel_valid & ready_s;
  assign id_ok_s  = ({1'b0, sel_id} < NUM_LIMIT);

  // Next-state and next-output decode; outputs are registered from these values.
  always_comb begin
    state_s      = state_r;
    counter_s    = counter_r;
    target_s     = target_r;
    proj_reset_s = proj_reset_r;
    active_id_s  = active_id_r;
    running_s    = running_r;
    sel_error_s  = 1'b0;
    case (state_r)
      PARK: begin
        if (counter_r == CNT_ZERO) begin
          state_s      = RUN;
          proj_reset_s = release_mask(target_r);
          active_id_s  = target_r;
          running_s    = 1'b1;
        end else begin
          counter_s = counter_r - CNT_W'(1);
        end
      end
      IDLE, RUN: begin
        if (accept_s) begin
          if (!sel_enable) begin
            state_s      = IDLE;
            counter_s    = CNT_ZERO;
            proj_reset_s = ALL_PARKED;
            running_s    = 1'b0;
          end else if (id_ok_s) begin
            // Parking happens on the accept edge, even when re-selecting the same id.
            state_s      = PARK;
            counter_s    = CNT_LOAD;
            target_s     = sel_id;
            proj_reset_s = ALL_PARKED;
            running_s    = 1'b0;
          end else begin
            sel_error_s = 1'b1;
          end
        end else begin
          sel_error_s = 1'b0;
        end
      end
      default: begin
        state_s      = IDLE;
        counter_s    = CNT_ZERO;
        proj_reset_s = ALL_PARKED;
        running_s    = 1'b0;
      end
    endcase
  end

  // State and output registers; reset parks all projects and drops the target.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r      <= IDLE;
      counter_r    <= CNT_ZERO;
      target_r     <= ID_ZERO;
      proj_reset_r <= ALL_PARKED;
      active_id_r  <= ID_ZERO;
      running_r    <= 1'b0;
      sel_error_r  <= 1'b0;
    end else begin
      state_r      <= state_s;
      counter_r    <= counter_s;
      target_r     <= target_s;
      proj_reset_r <= proj_reset_s;
      active_id_r  <= active_id_s;
      running_r    <= running_s;
      sel_error_r  <= sel_error_s;
    end
  end

  assign sel_ready  = ready_s;
  assign proj_reset = proj_reset_r;
  assign active_id  = active_id_r;
  assign running    = running_r;
  assign sel_error  = sel_error_r;

endmodule
